// File: rtl/fpsu_lane_ret_merge_pkg.sv
// Shared types and helpers for the SIMD FP store/convert retire merger.
// Lane count, status width, tag width and per-port depth are fixed here
// because the FIFO entry struct is built from them.
package fpsu_merge_pkg;

  localparam int unsigned LANES  = 2;
  localparam int unsigned RET_W  = 14;
  localparam int unsigned TAG_W  = 9;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned LIDX_W = (LANES > 1) ? $clog2(LANES) : 1;

  // MSB of the merged status marks a lane that never reported.
  localparam int unsigned         RET_TMO_BIT  = RET_W - 1;
  localparam logic [RET_W-1:0]    RET_TMO_MASK = RET_W'(1) << RET_TMO_BIT;

  typedef struct packed {
    logic             valid;
    logic [LANES-1:0] mask;
    logic [LANES-1:0] got;
    logic [RET_W-1:0] acc;
    logic [TAG_W-1:0] tag;
  } entry_t;

  typedef struct packed {
    logic             found;
    logic [PTR_W-1:0] idx;
  } match_t;

  // Oldest valid entry (walking from head) still waiting on the given lane.
  function automatic match_t first_expect(input entry_t           entries [DEPTH],
                                          input logic [PTR_W-1:0] head,
                                          input logic [LIDX_W-1:0] lane);
    match_t m;
    m = '0;
    // Walk youngest to oldest so the oldest match is the last one written.
    for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
      logic [PTR_W-1:0] i;
      i = head + PTR_W'(k);
      if (entries[i].valid && entries[i].mask[lane] && !entries[i].got[lane]) begin
        m.found = 1'b1;
        m.idx   = i;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/fpsu_lane_ret_merge_if.sv
// Issue / lane-result / retire bundle for fpsu_lane_ret_merge, all ports packed.
interface fpsu_lane_ret_merge_if #(
  parameter int unsigned PORTS = 6
);

  logic [PORTS-1:0]                                                   iss_en;
  logic [PORTS*fpsu_merge_pkg::LANES-1:0]                             iss_mask;
  logic [PORTS*fpsu_merge_pkg::TAG_W-1:0]                             iss_tag;
  logic [PORTS-1:0]                                                   iss_full;
  logic [PORTS*fpsu_merge_pkg::LANES-1:0]                             lane_ret_en;
  logic [PORTS*fpsu_merge_pkg::LANES*fpsu_merge_pkg::RET_W-1:0]       lane_ret;
  logic [PORTS-1:0]                                                   ret_en;
  logic [PORTS*fpsu_merge_pkg::RET_W-1:0]                             ret;
  logic [PORTS*fpsu_merge_pkg::TAG_W-1:0]                             ret_tag;
  logic [PORTS-1:0]                                                   err_sticky;

  // Issue side and lane units drive; retire side observes.
  modport master (
    output iss_en, iss_mask, iss_tag, lane_ret_en, lane_ret,
    input  iss_full, ret_en, ret, ret_tag, err_sticky
  );

  // The merger itself.
  modport slave (
    input  iss_en, iss_mask, iss_tag, lane_ret_en, lane_ret,
    output iss_full, ret_en, ret, ret_tag, err_sticky
  );

endinterface

// File: rtl/fpsu_lane_ret_merge_port.sv
// One issue port of the retire merger: in-flight FIFO, lane attach and
// in-order completion. Optional head-wait timeout under FPSU_MERGE_TIMEOUT_EN.
module fpsu_merge_port
  import fpsu_merge_pkg::*;
`ifdef FPSU_MERGE_TIMEOUT_EN
#(
  parameter int unsigned TIMEOUT = 63
)
`endif
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   iss_en,
  input  logic [LANES-1:0]       iss_mask,
  input  logic [TAG_W-1:0]       iss_tag,
  output logic                   iss_full,
  input  logic [LANES-1:0]       lane_ret_en,
  input  logic [LANES*RET_W-1:0] lane_ret,
  output logic                   ret_en,
  output logic [RET_W-1:0]       ret,
  output logic [TAG_W-1:0]       ret_tag,
  output logic                   err_sticky
);

  entry_t           ent_q [DEPTH];
  entry_t           ent_a [DEPTH];
  entry_t           ent_d [DEPTH];
  entry_t           head_a;
  match_t           hit;
  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  logic [CNT_W-1:0] count_q;
  logic             stray_c;
  logic             cmpl_c;
  logic             force_c;
  logic             pop_c;
  logic             push_c;
  logic             drop_c;

  // Full is judged on the registered count; a same-cycle pop still lets the issue in.
  assign iss_full = (count_q == CNT_W'(DEPTH));

  // Attach each lane strobe to the oldest entry still waiting on that lane.
  always_comb begin
    ent_a   = ent_q;
    stray_c = 1'b0;
    hit     = '0;
    for (int l = 0; l < int'(LANES); l++) begin
      if (lane_ret_en[LIDX_W'(l)]) begin
        hit = first_expect(ent_q, head_q, LIDX_W'(l));
        if (hit.found) begin
          ent_a[hit.idx].got[LIDX_W'(l)] = 1'b1;
          ent_a[hit.idx].acc = ent_a[hit.idx].acc | lane_ret[l*RET_W +: RET_W];
        end else begin
          stray_c = 1'b1;
        end
      end
    end
  end

  // Completion looks at the head after this cycle's attaches.
  assign head_a = ent_a[head_q];
  assign cmpl_c = head_a.valid && (head_a.got == head_a.mask);
  assign pop_c  = cmpl_c || force_c;

`ifdef FPSU_MERGE_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] wait_q;

  assign force_c = head_a.valid && !cmpl_c && (wait_q == TMO_W'(TIMEOUT));

  // Head-wait counter; restarts whenever the head retires.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_q <= '0;
    end else if (pop_c || !head_a.valid) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_q + TMO_W'(1);
    end
  end
`else
  assign force_c = 1'b0;
`endif

  // Pop the head, then write the new issue (tail may equal head when full).
  always_comb begin
    ent_d  = ent_a;
    push_c = iss_en && (!iss_full || pop_c);
    drop_c = iss_en && !push_c;
    if (pop_c) begin
      ent_d[head_q].valid = 1'b0;
    end
    if (push_c) begin
      ent_d[tail_q].valid = 1'b1;
      ent_d[tail_q].mask  = iss_mask;
      ent_d[tail_q].got   = '0;
      ent_d[tail_q].acc   = '0;
      ent_d[tail_q].tag   = iss_tag;
    end
  end

  // FIFO state, registered retire outputs and sticky error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent_q      <= '{default: '0};
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      ret_en     <= 1'b0;
      ret        <= '0;
      ret_tag    <= '0;
      err_sticky <= 1'b0;
    end else begin
      ent_q      <= ent_d;
      head_q     <= head_q + PTR_W'(pop_c);
      tail_q     <= tail_q + PTR_W'(push_c);
      count_q    <= count_q + CNT_W'(push_c) - CNT_W'(pop_c);
      ret_en     <= pop_c;
      ret        <= pop_c ? (head_a.acc | (force_c ? RET_TMO_MASK : '0)) : '0;
      ret_tag    <= pop_c ? head_a.tag : '0;
      err_sticky <= err_sticky | drop_c | stray_c | force_c;
    end
  end

endmodule

// File: rtl/fpsu_lane_ret_merge.sv
// Retire-status merger for the SIMD FP store/convert cluster: PORTS independent
// per-port mergers that OR lane status words and retire ops in issue order.
// Optional head-wait timeout: define FPSU_MERGE_TIMEOUT_EN.
module fpsu_lane_ret_merge
  import fpsu_merge_pkg::*;
#(
  parameter int unsigned PORTS = 6
`ifdef FPSU_MERGE_TIMEOUT_EN
  , parameter int unsigned TIMEOUT = 63
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  fpsu_lane_ret_merge_if.slave  bus
);

  // One merger per issue port; ports share nothing.
  for (genvar p = 0; p < int'(PORTS); p++) begin : g_port
    fpsu_merge_port
`ifdef FPSU_MERGE_TIMEOUT_EN
      #(.TIMEOUT(TIMEOUT))
`endif
      u_port (
        .clk         (clk),
        .rst         (rst),
        .iss_en      (bus.iss_en[p]),
        .iss_mask    (bus.iss_mask[p*LANES +: LANES]),
        .iss_tag     (bus.iss_tag[p*TAG_W +: TAG_W]),
        .iss_full    (bus.iss_full[p]),
        .lane_ret_en (bus.lane_ret_en[p*LANES +: LANES]),
        .lane_ret    (bus.lane_ret[p*LANES*RET_W +: LANES*RET_W]),
        .ret_en      (bus.ret_en[p]),
        .ret         (bus.ret[p*RET_W +: RET_W]),
        .ret_tag     (bus.ret_tag[p*TAG_W +: TAG_W]),
        .err_sticky  (bus.err_sticky[p])
      );
  end

endmodule

// File: tb/tb_fpsu_lane_ret_merge.sv
// Directed self-checking bench for fpsu_lane_ret_merge (6 ports, 2 lanes, depth 4).
module tb_fpsu_lane_ret_merge;
  import fpsu_merge_pkg::*;

  localparam int unsigned NP = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fpsu_lane_ret_merge_if #(.PORTS(NP)) bus ();

  fpsu_lane_ret_merge #(
    .PORTS(NP)
`ifdef FPSU_MERGE_TIMEOUT_EN
    , .TIMEOUT(8)
`endif
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.iss_en      = '0;
    bus.iss_mask    = '0;
    bus.iss_tag     = '0;
    bus.lane_ret_en = '0;
    bus.lane_ret    = '0;
  endtask

  task automatic issue(input int p, input logic [1:0] m, input logic [8:0] t);
    bus.iss_en[p +: 1]       = 1'b1;
    bus.iss_mask[p*2 +: 2]   = m;
    bus.iss_tag[p*9 +: 9]    = t;
  endtask

  task automatic lane(input int p, input int l, input logic [13:0] v);
    bus.lane_ret_en[p*2+l +: 1]      = 1'b1;
    bus.lane_ret[(p*2+l)*14 +: 14]   = v;
  endtask

  function automatic logic [13:0] ret_of(input int p);
    return bus.ret[p*14 +: 14];
  endfunction

  function automatic logic [8:0] tag_of(input int p);
    return bus.ret_tag[p*9 +: 9];
  endfunction

  task automatic test_reset();
    checks++; if (bus.ret_en !== 6'h00) begin errors++; $display("FAIL reset_ret_en got %h exp 00", bus.ret_en); end
    checks++; if (bus.ret !== '0) begin errors++; $display("FAIL reset_ret got %h exp 0", bus.ret); end
    checks++; if (bus.ret_tag !== '0) begin errors++; $display("FAIL reset_ret_tag got %h exp 0", bus.ret_tag); end
    checks++; if (bus.err_sticky !== 6'h00) begin errors++; $display("FAIL reset_err got %h exp 00", bus.err_sticky); end
    checks++; if (bus.iss_full !== 6'h00) begin errors++; $display("FAIL reset_full got %h exp 00", bus.iss_full); end
  endtask

  task automatic test_basic();
    logic [5:0] exp_en;
    for (int c = 0; c < 8; c++) begin
      idle();
      if (c == 0) issue(0, 2'b11, 9'h015);
      if (c == 3) lane(0, 0, 14'h0004);
      if (c == 5) lane(0, 1, 14'h0100);
      tick();
      exp_en = (c + 1 == 6) ? 6'b000001 : 6'b000000;
      checks++; if (bus.ret_en !== exp_en) begin errors++; $display("FAIL basic_ret_en cyc %0d got %h exp %h", c + 1, bus.ret_en, exp_en); end
      if (c + 1 == 6) begin
        checks++; if (ret_of(0) !== 14'h0104) begin errors++; $display("FAIL basic_ret got %h exp 0104", ret_of(0)); end
        checks++; if (tag_of(0) !== 9'h015) begin errors++; $display("FAIL basic_tag got %h exp 015", tag_of(0)); end
      end
    end
    checks++; if (bus.err_sticky !== 6'h00) begin errors++; $display("FAIL basic_err got %h exp 00", bus.err_sticky); end
  endtask

  task automatic test_skew();
    logic [5:0] exp_en;
    for (int c = 0; c < 8; c++) begin
      idle();
      if (c == 0) issue(1, 2'b11, 9'h00A);
      if (c == 1) issue(1, 2'b11, 9'h00B);
      if (c == 2) lane(1, 1, 14'h0010);
      if (c == 3) lane(1, 1, 14'h0020);
      if (c == 4) lane(1, 0, 14'h0001);
      if (c == 5) lane(1, 0, 14'h0002);
      tick();
      exp_en = (c + 1 == 5 || c + 1 == 6) ? 6'b000010 : 6'b000000;
      checks++; if (bus.ret_en !== exp_en) begin errors++; $display("FAIL skew_ret_en cyc %0d got %h exp %h", c + 1, bus.ret_en, exp_en); end
      if (c + 1 == 5) begin
        checks++; if (ret_of(1) !== 14'h0011) begin errors++; $display("FAIL skew_ret_a got %h exp 0011", ret_of(1)); end
        checks++; if (tag_of(1) !== 9'h00A) begin errors++; $display("FAIL skew_tag_a got %h exp 00a", tag_of(1)); end
      end
      if (c + 1 == 6) begin
        checks++; if (ret_of(1) !== 14'h0022) begin errors++; $display("FAIL skew_ret_b got %h exp 0022", ret_of(1)); end
        checks++; if (tag_of(1) !== 9'h00B) begin errors++; $display("FAIL skew_tag_b got %h exp 00b", tag_of(1)); end
      end
    end
    checks++; if (bus.err_sticky[1] !== 1'b0) begin errors++; $display("FAIL skew_err got %b exp 0", bus.err_sticky[1]); end
  endtask

  task automatic test_full_drop();
    for (int c = 0; c < 4; c++) begin
      idle(); issue(2, 2'b01, 9'(c + 1)); tick();
    end
    idle();
    checks++; if (bus.iss_full !== 6'b000100) begin errors++; $display("FAIL drop_full got %h exp 04", bus.iss_full); end
    issue(2, 2'b01, 9'h005); tick(); idle();
    checks++; if (bus.err_sticky !== 6'b000100) begin errors++; $display("FAIL drop_err got %h exp 04", bus.err_sticky); end
    checks++; if (bus.iss_full !== 6'b000100) begin errors++; $display("FAIL drop_full2 got %h exp 04", bus.iss_full); end
    for (int k = 0; k < 5; k++) begin
      idle();
      if (k < 4) lane(2, 0, 14'(14'h100 + k));
      tick();
      if (k < 4) begin
        checks++; if (bus.ret_en !== 6'b000100) begin errors++; $display("FAIL drop_drain_en %0d got %h exp 04", k, bus.ret_en); end
        checks++; if (tag_of(2) !== 9'(k + 1)) begin errors++; $display("FAIL drop_drain_tag %0d got %h exp %h", k, tag_of(2), 9'(k + 1)); end
        checks++; if (ret_of(2) !== 14'(14'h100 + k)) begin errors++; $display("FAIL drop_drain_ret %0d got %h exp %h", k, ret_of(2), 14'(14'h100 + k)); end
      end else begin
        checks++; if (bus.ret_en !== 6'b000000) begin errors++; $display("FAIL drop_no_fifth got %h exp 00", bus.ret_en); end
      end
    end
    checks++; if (bus.iss_full !== 6'b000000) begin errors++; $display("FAIL drop_empty got %h exp 00", bus.iss_full); end
  endtask

  task automatic test_full_pop();
    for (int c = 0; c < 4; c++) begin
      idle(); issue(3, 2'b01, 9'(9'h011 + c)); tick();
    end
    idle();
    issue(3, 2'b01, 9'h015);
    lane(3, 0, 14'h0201);
    tick();
    checks++; if (bus.ret_en !== 6'b001000) begin errors++; $display("FAIL pop_ret_en got %h exp 08", bus.ret_en); end
    checks++; if (tag_of(3) !== 9'h011) begin errors++; $display("FAIL pop_tag got %h exp 011", tag_of(3)); end
    checks++; if (bus.iss_full !== 6'b001000) begin errors++; $display("FAIL pop_full got %h exp 08", bus.iss_full); end
    checks++; if (bus.err_sticky[3] !== 1'b0) begin errors++; $display("FAIL pop_err got %b exp 0", bus.err_sticky[3]); end
    for (int k = 0; k < 4; k++) begin
      idle(); lane(3, 0, 14'(14'h202 + k)); tick();
      checks++; if (tag_of(3) !== 9'(9'h012 + k)) begin errors++; $display("FAIL pop_drain_tag %0d got %h exp %h", k, tag_of(3), 9'(9'h012 + k)); end
    end
    idle();
    checks++; if (bus.iss_full[3] !== 1'b0) begin errors++; $display("FAIL pop_empty got %b exp 0", bus.iss_full[3]); end
    checks++; if (bus.err_sticky[3] !== 1'b0) begin errors++; $display("FAIL pop_err_end got %b exp 0", bus.err_sticky[3]); end
  endtask

  task automatic test_spurious();
    idle(); lane(4, 1, 14'h3FFF); tick(); idle();
    checks++; if (bus.err_sticky[4] !== 1'b1) begin errors++; $display("FAIL spur_err got %b exp 1", bus.err_sticky[4]); end
    checks++; if (bus.ret_en !== 6'b000000) begin errors++; $display("FAIL spur_ret_en got %h exp 00", bus.ret_en); end
  endtask

  task automatic test_empty_mask();
    idle(); issue(5, 2'b00, 9'h1AB); tick(); idle();
    checks++; if (bus.ret_en !== 6'b000000) begin errors++; $display("FAIL m0_early got %h exp 00", bus.ret_en); end
    tick();
    checks++; if (bus.ret_en !== 6'b100000) begin errors++; $display("FAIL m0_ret_en got %h exp 20", bus.ret_en); end
    checks++; if (ret_of(5) !== 14'h0000) begin errors++; $display("FAIL m0_ret got %h exp 0000", ret_of(5)); end
    checks++; if (tag_of(5) !== 9'h1AB) begin errors++; $display("FAIL m0_tag got %h exp 1ab", tag_of(5)); end
    tick();
    checks++; if (bus.ret_en !== 6'b000000) begin errors++; $display("FAIL m0_once got %h exp 00", bus.ret_en); end
    checks++; if (bus.err_sticky[5] !== 1'b0) begin errors++; $display("FAIL m0_err got %b exp 0", bus.err_sticky[5]); end
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 4; c++) begin
      idle();
      if (c < 3) issue(0, 2'b11, 9'(9'h031 + c));
      if (c == 3) lane(0, 0, 14'h0004);
      tick();
    end
    idle();
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.ret_en !== 6'h00) begin errors++; $display("FAIL rmid_ret_en got %h exp 00", bus.ret_en); end
    checks++; if (bus.ret !== '0) begin errors++; $display("FAIL rmid_ret got %h exp 0", bus.ret); end
    checks++; if (bus.ret_tag !== '0) begin errors++; $display("FAIL rmid_tag got %h exp 0", bus.ret_tag); end
    checks++; if (bus.err_sticky !== 6'h00) begin errors++; $display("FAIL rmid_err got %h exp 00", bus.err_sticky); end
    checks++; if (bus.iss_full !== 6'h00) begin errors++; $display("FAIL rmid_full got %h exp 00", bus.iss_full); end
    tick(); tick();
    rst = 1'b0;
    tick();
    issue(0, 2'b01, 9'h040); tick(); idle();
    lane(0, 0, 14'h0008); tick(); idle();
    checks++; if (bus.ret_en !== 6'b000001) begin errors++; $display("FAIL rmid_new_en got %h exp 01", bus.ret_en); end
    checks++; if (ret_of(0) !== 14'h0008) begin errors++; $display("FAIL rmid_new_ret got %h exp 0008", ret_of(0)); end
    checks++; if (tag_of(0) !== 9'h040) begin errors++; $display("FAIL rmid_new_tag got %h exp 040", tag_of(0)); end
    checks++; if (bus.err_sticky !== 6'h00) begin errors++; $display("FAIL rmid_clean got %h exp 00", bus.err_sticky); end
    lane(0, 1, 14'h0001); tick(); idle();
    checks++; if (bus.err_sticky !== 6'b000001) begin errors++; $display("FAIL rmid_stale_err got %h exp 01", bus.err_sticky); end
    checks++; if (bus.ret_en !== 6'h00) begin errors++; $display("FAIL rmid_stale_en got %h exp 00", bus.ret_en); end
  endtask

`ifdef FPSU_MERGE_TIMEOUT_EN
  task automatic test_timeout();
    logic [5:0] exp_en;
    for (int c = 0; c < 12; c++) begin
      idle();
      if (c == 0) issue(1, 2'b11, 9'h077);
      if (c == 1) lane(1, 0, 14'h0003);
      tick();
      exp_en = (c + 1 == 10) ? 6'b000010 : 6'b000000;
      checks++; if (bus.ret_en !== exp_en) begin errors++; $display("FAIL tmo_ret_en cyc %0d got %h exp %h", c + 1, bus.ret_en, exp_en); end
      if (c + 1 == 10) begin
        checks++; if (ret_of(1) !== 14'h2003) begin errors++; $display("FAIL tmo_ret got %h exp 2003", ret_of(1)); end
        checks++; if (tag_of(1) !== 9'h077) begin errors++; $display("FAIL tmo_tag got %h exp 077", tag_of(1)); end
        checks++; if (bus.err_sticky[1] !== 1'b1) begin errors++; $display("FAIL tmo_err got %b exp 1", bus.err_sticky[1]); end
      end
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    tick(); tick();
    test_reset();
    rst = 1'b0;
    tick();
    test_basic();
    test_skew();
    test_full_drop();
    test_full_pop();
    test_spurious();
    test_empty_mask();
    test_reset_mid();
`ifdef FPSU_MERGE_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpsu_lane_ret_merge.md
Name: fpsu_lane_ret_merge

Overview:
- Parametrised retire-status merger for the SIMD FP store/convert cluster.
- Generalises the fixed two-half (H/L) retire OR into LANES lanes across PORTS issue ports.
- Lanes may report with different, variable latency; the block buffers in-flight ops per port and emits one merged retire word per op, in issue order, once every participating lane has reported.
- Sits between the per-lane fun_fpuSL-class units and the retire bus.

Parameters:
- PORTS, 6, number of issue ports (u1..u6 equivalents)
- LANES, 2, SIMD lanes per port (2 = H/L)
- RET_W, 14, retire status width per lane and merged
- DEPTH, 4, in-flight ops per port (power of 2, >=2)
- TAG_W, 9, op tag width carried to retire
- TIMEOUT, 63, head-wait cycles before forced completion (optional feature only)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- iss_en  in  PORTS  issue strobe per port
- iss_mask  in  PORTS*LANES  lanes participating in the issued op
- iss_tag  in  PORTS*TAG_W  op tag
- iss_full  out  PORTS  port FIFO full (combinational from count)
- lane_ret_en  in  PORTS*LANES  lane result strobe
- lane_ret  in  PORTS*LANES*RET_W  lane status word
- ret_en  out  PORTS  merged retire strobe (registered)
- ret  out  PORTS*RET_W  merged status, OR of participating lane words
- ret_tag  out  PORTS*TAG_W  tag of retired op
- err_sticky  out  PORTS  sticky protocol error

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high. All state clears on rst assertion, including mid-operation: every FIFO is emptied, in-flight ops are discarded, ret_en/ret/ret_tag/err_sticky read 0, and iss_full reads 0.
- Ports are fully independent; every rule below applies per port.
- FIFO entry fields: valid, mask[LANES], got[LANES], acc[RET_W], tag.
- Issue, when iss_en and not full:
  - Write at the tail with got=0, acc=0; tail and count increment.
  - iss_en while full: the op is dropped and err_sticky is set.
- Lane result, when lane_ret_en[l]:
  - Attaches to the oldest valid entry with mask[l]=1 and got[l]=0.
  - That entry gets got[l]=1 and acc |= lane_ret[l].
  - No such entry exists: the result is ignored and err_sticky is set.
  - Lanes return in order per lane but may run ahead across entries; a lane may complete entry 1 before another lane finishes entry 0.
- Completion: the head entry is complete when got==mask, including mask==0.
  - The cycle after completion, ret_en=1, ret=acc, ret_tag=tag.
  - The head pops on the completion cycle, so latency from the last lane strobe to ret_en is 1 cycle.
  - Lane results arriving in the same cycle as the completion check are included: completion uses next-state got/acc. The last strobe and ret_en are therefore exactly 1 cycle apart.
- Throughput: at most one retire per port per cycle.
  - A younger entry that is already complete retires on the following cycle(s).
- Simultaneous issue and pop:
  - When full, the issue is accepted because the pop frees a slot (full is computed after pop).
  - When empty, an issue with mask==0 retires 2 cycles after iss_en: it is written at cycle N, detected at N+1, and ret_en is asserted at N+2.
- Pointers wrap modulo DEPTH; count is $clog2(DEPTH)+1 bits wide.
- err_sticky clears only on rst.

Optional Feature:
- Macro: FPSU_MERGE_TIMEOUT_EN.
- Defined:
  - Per-port wait counter: cleared on pop or when the head changes, otherwise increments while the head is valid and incomplete.
  - When the counter reaches TIMEOUT, the head force-retires with ret=acc|{1'b1,(RET_W-1)'b0}. The MSB marks a lane timeout.
  - The head pops, err_sticky is set, and late results for that entry are treated as unexpected.
- Undefined: no counter; the head waits indefinitely.

Decomposition:
- Package fpsu_merge_pkg: entry struct typedef (mask, got, acc, tag, valid), RET_TMO_BIT constant, and function first_expect(entries, lane) returning the oldest-match index.
- Sub-module fpsu_merge_port holds one port's FIFO, attach logic and completion logic. The top generates PORTS instances.

Test Plan:
- Basic in-order case (LANES=2): issue tag=0x15, mask=2'b11. Lane0 returns 0x0004 at cycle 3 and lane1 returns 0x0100 at cycle 5. Expect ret_en at cycle 6 with ret=0x0104, ret_tag=0x15.
- Cross-entry skew: issue A(mask 11) then B(mask 11). Lane1 returns for A, then for B, then lane0 returns for A and B on consecutive cycles. Expect A to retire first, then B on the next cycle; the flag ORs must not mix between entries.
- Full, drop and pop: fill all DEPTH=4 entries, then issue a 5th with no pop. Expect iss_full=1, the op dropped and err_sticky=1. Repeat with a same-cycle completion of the head; expect the 5th to be accepted and err_sticky unchanged.
- Spurious and empty-mask cases:
  - A lane_ret_en strobe on an empty port is ignored and sets err_sticky.
  - An issue with mask=0 on an empty port gives ret_en 2 cycles later with ret=0.
- Reset mid-flight: assert rst with 3 entries pending and partial got. Outputs go 0 immediately. After release, a new op retires normally, and stale lane strobes flag err_sticky.
- FPSU_MERGE_TIMEOUT_EN with TIMEOUT=8: lane1 never returns. Expect ret_en 9 cycles after the head becomes valid, with the ret MSB set and err_sticky=1.
